seq_detect_prog: RTL and testbench
==================================

# seq_detect_prog

Programmable serial sequence detector, successor to the fixed-pattern `seq` detector. It matches a runtime-loadable pattern of `PAT_LEN` bits on a one-bit serial input qualified by `in_valid`. Overlapping or non-overlapping detection is selected by parameter, and an optional saturating match counter can be compiled in. It sits between a serial bit source and downstream event logic, and produces a registered single-cycle `match` pulse.

## Interface
- `PAT_LEN`, 4: pattern length in bits, legal range 2..16.
- `PAT_INIT`, 4'b1011: pattern loaded at reset; width `PAT_LEN`.
- `OVERLAP`, 1: 1 = overlapping detection; 0 = history restarts after every match.
- `CNT_WIDTH`, 8: match counter width, legal range 1..32.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `enable`  in  1  detector active; low forces IDLE.
- `cfg_load`  in  1  load `cfg_pattern`; clears history.
- `cfg_pattern`  in  PAT_LEN  new pattern; first received bit is compared to the MSB.
- `in_valid`  in  1  `seq_in` is sampled this edge.
- `seq_in`  in  1  serial data bit.
- `match`  out  1  one-cycle pulse: the last `PAT_LEN` valid bits equal the pattern.
- `filling`  out  1  high while fewer than `PAT_LEN` bits have been collected since the last clear.
- `match_cnt`  out  CNT_WIDTH  saturating match count; present only with `SEQ_DET_COUNT_EN`.
- `cnt_clr`  in  1  synchronous counter clear; present only with `SEQ_DET_COUNT_EN`.

## Operation
- Storage:
  - `hist` is a PAT_LEN-bit shift register. On a valid bit it shifts left and `seq_in` enters at the LSB.
  - `fill` is a saturating count from 0 to PAT_LEN.
- FSM states: IDLE, FILL, DETECT.
  - IDLE: entered at reset or whenever `enable`=0. `fill`=0 and valid bits are ignored. On `enable`=1, go to FILL.
  - FILL: each valid bit shifts into `hist` and increments `fill`. When `fill` reaches PAT_LEN, go to DETECT.
  - DETECT: each valid bit shifts into `hist`. If the new `hist` equals the pattern, pulse `match`. If `OVERLAP`=0 and a match occurs, set `fill`=0 and return to FILL.
- Pattern comparison: the next-state `hist` (shifted value including the current bit) is compared against the stored pattern.
- `cfg_load`=1:
  - Pattern register ← `cfg_pattern`, `hist`=0, `fill`=0.
  - If enabled, state → FILL.
  - A same-edge `in_valid` bit is discarded.
  - `cfg_load` has priority over `in_valid`.
- `enable` dropping mid-sequence discards the partial history. There is no match on that edge.
- `in_valid`=0 holds all state; gaps between valid bits are transparent.
- Counter:
  - Increments on every `match`.
  - Saturates at all-ones.
  - `cnt_clr` wins over a simultaneous match.

## Timing
- Reset values: `match`=0, `filling`=1, `match_cnt`=0, `hist`=0, `fill`=0, state IDLE, pattern=`PAT_INIT`.
- Latency: `match` is registered high for exactly one cycle after the edge that samples the completing bit.
- Back-to-back matches with `OVERLAP`=1 give consecutive `match` pulses; for example, pattern 2'b11 with input 1,1,1.
- A first match needs at least PAT_LEN valid bits after reset, `cfg_load`, or enable.
- `filling` reflects `fill` < PAT_LEN combinationally from registers.
- `match_cnt` updates on the same edge that raises `match`.

## Configuration
- `SEQ_DET_COUNT_EN` defined:
  - `match_cnt` and `cnt_clr` ports exist.
  - The saturating counter is built.
- Not defined:
  - The ports are absent and no counter logic is generated.
  - Match and FSM behaviour are identical.

## Structure
- `seq_det_pkg` holds:
  - The state enum `seq_det_state_e` {IDLE, FILL, DETECT}.
  - The `SEQ_DET_MAX_LEN`=16 constant.
  - A parameter-legality check function.
- Sub-module `seq_det_sat_cnt` implements the generic saturating counter with clear. It is instantiated only under `SEQ_DET_COUNT_EN`.

## Test plan
- Reset release, `enable`=1, PAT_LEN=4, pattern 1011, OVERLAP=1, bits 1,0,1,0,1,1,0,1,1 → `match` one cycle after bits 6 and 9; `match_cnt`=2.
- Same stimulus with OVERLAP=0 → single match after bit 6; bits 7–9 do not match because the history restarted.
- `cfg_load` pattern 101, PAT_LEN=3, OVERLAP=1, same bits → matches after bits 3, 5 and 8. With OVERLAP=0 → matches after bits 3 and 8.
- `in_valid` gaps of 0–3 idle cycles between bits → identical match positions. `cfg_load` together with a valid bit discards that bit, and `filling`=1 afterwards.
- `enable` dropped after 3 of 4 pattern bits, then re-enabled and the full pattern sent → no spurious match, then exactly one match.
- CNT_WIDTH=2, five matches → `match_cnt` saturates at 3. `cnt_clr` asserted together with a match → `match_cnt`=0. `rst_n` pulsed mid-pattern → all outputs take their reset values immediately.

Source files
------------

// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types, limits and parameter check for the programmable sequence detector
package seq_det_pkg;

    localparam int SEQ_DET_MAX_LEN = 16;

    // Width of the fill counter: wide enough to hold SEQ_DET_MAX_LEN itself
    localparam int SEQ_DET_FILL_W = $clog2(SEQ_DET_MAX_LEN + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        DETECT = 2'd2
    } seq_det_state_e;

    function automatic bit seq_det_params_ok(input int pat_len, input int cnt_width);
        return (pat_len >= 2) && (pat_len <= SEQ_DET_MAX_LEN) &&
               (cnt_width >= 1) && (cnt_width <= 32);
    endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// rtl/seq_det_sat_cnt.sv - saturating up-counter with synchronous clear (clear wins over increment)
module seq_det_sat_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: clear first, otherwise step unless already all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_detect_prog.sv
// rtl/seq_detect_prog.sv - programmable serial pattern detector; SEQ_DET_COUNT_EN adds match_cnt/cnt_clr
module seq_detect_prog
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN   = 4,
    parameter logic [PAT_LEN-1:0] PAT_INIT  = 4'b1011,
    parameter bit                 OVERLAP   = 1'b1,
    parameter int                 CNT_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               cfg_load,
    input  logic [PAT_LEN-1:0] cfg_pattern,
    input  logic               in_valid,
    input  logic               seq_in,
    output logic               match,
    output logic               filling
`ifdef SEQ_DET_COUNT_EN
    ,
    input  logic               cnt_clr,
    output logic [CNT_WIDTH-1:0] match_cnt
`endif
);

    localparam logic [SEQ_DET_FILL_W-1:0] FILL_FULL = SEQ_DET_FILL_W'(PAT_LEN);
    localparam logic [SEQ_DET_FILL_W-1:0] FILL_LAST = SEQ_DET_FILL_W'(PAT_LEN - 1);

    if (!seq_det_params_ok(PAT_LEN, CNT_WIDTH)) begin : g_bad_params
        $error("seq_detect_prog: PAT_LEN or CNT_WIDTH out of range");
    end

    seq_det_state_e              state_q, state_d;
    logic [PAT_LEN-1:0]          hist_q, hist_d;
    logic [PAT_LEN-1:0]          pat_q, pat_d;
    logic [SEQ_DET_FILL_W-1:0]   fill_q, fill_d;
    logic                        match_q, match_d;
    logic [PAT_LEN-1:0]          hist_shift;
    logic                        full_now;

    // Next state, history, fill level and match decision for this edge
    always_comb begin
        state_d    = state_q;
        hist_d     = hist_q;
        pat_d      = pat_q;
        fill_d     = fill_q;
        match_d    = 1'b0;
        hist_shift = {hist_q[PAT_LEN-2:0], seq_in};
        // The completing bit of a fill is compared too, so PAT_LEN bits suffice
        full_now   = (state_q == DETECT) || (fill_q == FILL_LAST);

        if (cfg_load) begin
            pat_d   = cfg_pattern;
            hist_d  = '0;
            fill_d  = '0;
            state_d = enable ? FILL : IDLE;
        end else if (!enable) begin
            hist_d  = '0;
            fill_d  = '0;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    fill_d  = '0;
                    state_d = FILL;
                end
                FILL, DETECT: begin
                    if (in_valid) begin
                        hist_d = hist_shift;
                        if (full_now) begin
                            fill_d  = FILL_FULL;
                            state_d = DETECT;
                            if (hist_shift == pat_q) begin
                                match_d = 1'b1;
                                if (!OVERLAP) begin
                                    fill_d  = '0;
                                    state_d = FILL;
                                end
                            end
                        end else begin
                            fill_d = fill_q + 1'b1;
                        end
                    end
                end
                default: begin
                    fill_d  = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Detector registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hist_q  <= '0;
            pat_q   <= PAT_INIT;
            fill_q  <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            pat_q   <= pat_d;
            fill_q  <= fill_d;
            match_q <= match_d;
        end
    end

    assign match   = match_q;
    assign filling = (fill_q < FILL_FULL);

`ifdef SEQ_DET_COUNT_EN
    // Counter steps on the same edge that registers the match pulse
    seq_det_sat_cnt #(
        .WIDTH (CNT_WIDTH)
    ) u_sat_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (match_d),
        .cnt   (match_cnt)
    );
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// tb/tb_seq_detect_prog.sv - directed table-driven bench for seq_detect_prog
module tb_seq_detect_prog;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       cfg_load;
    logic [3:0] cfg_pat4;
    logic [2:0] cfg_pat3;
    logic       in_valid;
    logic       seq_in;
    logic       cnt_clr;
    logic       m4o, m4n, m3o, m3n;
    logic       f4o, f4n, f3o, f3n;
    logic [7:0] cnt4o;
    logic [1:0] cnt4n;
    logic [7:0] cnt3o, cnt3n;

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        bit v;
        bit d;
        bit m4o;
        bit m4n;
        bit m3o;
        bit m3n;
    } vec_t;

    vec_t tbl[9];

    seq_detect_prog #(.PAT_LEN(4), .PAT_INIT(4'b1011), .OVERLAP(1'b1), .CNT_WIDTH(8)) u4o (
        .clk(clk), .rst_n(rst_n), .enable(enable), .cfg_load(cfg_load), .cfg_pattern(cfg_pat4),
        .in_valid(in_valid), .seq_in(seq_in), .match(m4o), .filling(f4o)
`ifdef SEQ_DET_COUNT_EN
        , .cnt_clr(cnt_clr), .match_cnt(cnt4o)
`endif
    );

    seq_detect_prog #(.PAT_LEN(4), .PAT_INIT(4'b1011), .OVERLAP(1'b0), .CNT_WIDTH(2)) u4n (
        .clk(clk), .rst_n(rst_n), .enable(enable), .cfg_load(cfg_load), .cfg_pattern(cfg_pat4),
        .in_valid(in_valid), .seq_in(seq_in), .match(m4n), .filling(f4n)
`ifdef SEQ_DET_COUNT_EN
        , .cnt_clr(cnt_clr), .match_cnt(cnt4n)
`endif
    );

    seq_detect_prog #(.PAT_LEN(3), .PAT_INIT(3'b111), .OVERLAP(1'b1), .CNT_WIDTH(8)) u3o (
        .clk(clk), .rst_n(rst_n), .enable(enable), .cfg_load(cfg_load), .cfg_pattern(cfg_pat3),
        .in_valid(in_valid), .seq_in(seq_in), .match(m3o), .filling(f3o)
`ifdef SEQ_DET_COUNT_EN
        , .cnt_clr(cnt_clr), .match_cnt(cnt3o)
`endif
    );

    seq_detect_prog #(.PAT_LEN(3), .PAT_INIT(3'b111), .OVERLAP(1'b0), .CNT_WIDTH(8)) u3n (
        .clk(clk), .rst_n(rst_n), .enable(enable), .cfg_load(cfg_load), .cfg_pattern(cfg_pat3),
        .in_valid(in_valid), .seq_in(seq_in), .match(m3n), .filling(f3n)
`ifdef SEQ_DET_COUNT_EN
        , .cnt_clr(cnt_clr), .match_cnt(cnt3n)
`endif
    );

`ifndef SEQ_DET_COUNT_EN
    assign cnt4o = '0;
    assign cnt4n = '0;
    assign cnt3o = '0;
    assign cnt3n = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic d);
        in_valid = v;
        seq_in   = d;
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg;
        cfg_load = 1'b1;
        cfg_pat4 = 4'b1011;
        cfg_pat3 = 3'b101;
        step(1'b0, 1'b0);
        cfg_load = 1'b0;
    endtask

    task automatic chk_all(input string tag, input int i, input vec_t e);
        chk($sformatf("%s m4o[%0d]", tag, i), {31'd0, m4o}, {31'd0, e.m4o});
        chk($sformatf("%s m4n[%0d]", tag, i), {31'd0, m4n}, {31'd0, e.m4n});
        chk($sformatf("%s m3o[%0d]", tag, i), {31'd0, m3o}, {31'd0, e.m3o});
        chk($sformatf("%s m3n[%0d]", tag, i), {31'd0, m3n}, {31'd0, e.m3n});
    endtask

    initial begin
        vec_t zero_vec;
        zero_vec = '{v: 1'b0, d: 1'b0, m4o: 1'b0, m4n: 1'b0, m3o: 1'b0, m3n: 1'b0};
        // Stream 1,0,1,0,1,1,0,1,1: 1011 matches at bits 6,9 (overlap) or 6 (restart);
        // 101 matches at bits 3,5,8 (overlap) or 3,8 (restart)
        tbl[0] = '{1, 1, 0, 0, 0, 0};
        tbl[1] = '{1, 0, 0, 0, 0, 0};
        tbl[2] = '{1, 1, 0, 0, 1, 1};
        tbl[3] = '{1, 0, 0, 0, 0, 0};
        tbl[4] = '{1, 1, 0, 0, 1, 0};
        tbl[5] = '{1, 1, 1, 1, 0, 0};
        tbl[6] = '{1, 0, 0, 0, 0, 0};
        tbl[7] = '{1, 1, 0, 0, 1, 1};
        tbl[8] = '{1, 1, 1, 0, 0, 0};

        rst_n    = 1'b0;
        enable   = 1'b0;
        cfg_load = 1'b0;
        cfg_pat4 = 4'b0000;
        cfg_pat3 = 3'b000;
        in_valid = 1'b0;
        seq_in   = 1'b0;
        cnt_clr  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset m4o", {31'd0, m4o}, 32'd0);
        chk("reset f4o", {31'd0, f4o}, 32'd1);
        chk("reset m3o", {31'd0, m3o}, 32'd0);
        chk("reset f3n", {31'd0, f3n}, 32'd1);
`ifdef SEQ_DET_COUNT_EN
        chk("reset cnt4o", {24'd0, cnt4o}, 32'd0);
`endif

        rst_n  = 1'b1;
        enable = 1'b1;
        load_cfg();

        // Back-to-back valid bits
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].v, tbl[i].d);
            chk_all("nogap", i, tbl[i]);
        end
        chk("nogap f4n", {31'd0, f4n}, 32'd1);
        chk("nogap f4o", {31'd0, f4o}, 32'd0);
`ifdef SEQ_DET_COUNT_EN
        chk("nogap cnt4o", {24'd0, cnt4o}, 32'd2);
        chk("nogap cnt3o", {24'd0, cnt3o}, 32'd3);
`endif

        // Same stream with 0..3 idle cycles before each bit
        load_cfg();
        for (int i = 0; i < 9; i++) begin
            for (int g = 0; g < (i % 4); g++) begin
                step(1'b0, 1'b1);
                chk_all("gap idle", i, zero_vec);
            end
            step(tbl[i].v, tbl[i].d);
            chk_all("gap", i, tbl[i]);
        end

        // cfg_load with a same-edge valid bit: that bit must be dropped
        cfg_load = 1'b1;
        step(1'b1, 1'b1);
        cfg_load = 1'b0;
        chk("load+valid f4o", {31'd0, f4o}, 32'd1);
        chk("load+valid m4o", {31'd0, m4o}, 32'd0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("dropped bit m4o", {31'd0, m4o}, 32'd0);
        chk("dropped bit f4o", {31'd0, f4o}, 32'd1);
        step(1'b1, 1'b1);
        chk("fill done m4o", {31'd0, m4o}, 32'd0);
        chk("fill done f4o", {31'd0, f4o}, 32'd0);

        // Enable dropped after three pattern bits
        load_cfg();
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("pre-drop m4o", {31'd0, m4o}, 32'd0);
        enable = 1'b0;
        step(1'b1, 1'b1);
        chk("disabled m4o", {31'd0, m4o}, 32'd0);
        chk("disabled f4o", {31'd0, f4o}, 32'd1);
        enable = 1'b1;
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        chk("reenable bit1 m4o", {31'd0, m4o}, 32'd0);
        step(1'b1, 1'b0);
        chk("reenable bit2 m4o", {31'd0, m4o}, 32'd0);
        step(1'b1, 1'b1);
        chk("reenable bit3 m4o", {31'd0, m4o}, 32'd0);
        step(1'b1, 1'b1);
        chk("reenable bit4 m4o", {31'd0, m4o}, 32'd1);
        step(1'b0, 1'b0);
        chk("pulse end m4o", {31'd0, m4o}, 32'd0);

`ifdef SEQ_DET_COUNT_EN
        // Two-bit counter saturates at 3, clear beats a simultaneous match
        load_cfg();
        cnt_clr = 1'b1;
        step(1'b0, 1'b0);
        cnt_clr = 1'b0;
        chk("cleared cnt4n", {30'd0, cnt4n}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b1);
            step(1'b1, 1'b0);
            step(1'b1, 1'b1);
            step(1'b1, 1'b1);
            chk($sformatf("sat m4n[%0d]", k), {31'd0, m4n}, 32'd1);
            chk($sformatf("sat cnt4n[%0d]", k), {30'd0, cnt4n}, (k < 3) ? k + 1 : 3);
        end
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        cnt_clr = 1'b1;
        step(1'b1, 1'b1);
        cnt_clr = 1'b0;
        chk("clr+match m4n", {31'd0, m4n}, 32'd1);
        chk("clr+match cnt4n", {30'd0, cnt4n}, 32'd0);
`endif

        // Asynchronous reset while a match pulse is high
        load_cfg();
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("pre-reset m4o", {31'd0, m4o}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async reset m4o", {31'd0, m4o}, 32'd0);
        chk("async reset f4o", {31'd0, f4o}, 32'd1);
`ifdef SEQ_DET_COUNT_EN
        chk("async reset cnt4o", {24'd0, cnt4o}, 32'd0);
`endif
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
